seg_led_scan: RTL and testbench



---
 rtl/seg_led_pkg.sv | 62 ++++++
 rtl/seg_led_scan_bin2bcd.sv | 63 ++++++
 rtl/seg_led_scan.sv | 174 +++++++++++++++++
 tb/tb_seg_led_scan.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_led_pkg
// Purpose  : Shared digit codes, segment patterns and sizing helpers for the
//            multiplexed seven-segment driver.
// Revision : 1.0
// ============================================================================
package seg_led_pkg;

  // 0-9 are decimal digits; 10 and 11 are the two non-numeric glyphs.
  typedef logic [3:0] digit_t;

  localparam digit_t     c_dig_blank = 4'd10;
  localparam digit_t     c_dig_minus = 4'd11;
  localparam logic [7:0] c_seg_blank = 8'h00;
  localparam logic [7:0] c_seg_minus = 8'h40;
  localparam logic [7:0] c_seg_dp    = 8'h80;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Number of decimal digits needed for the largest unsigned value of width bits.
  function automatic int bcd_digits(input int width);
    longint m;
    int     n;
    m = (longint'(1) << width) - 1;
    n = 1;
    while (m >= 10) begin
      m = m / 10;
      n++;
    end
    return n;
  endfunction

  function automatic logic [7:0] seg_code(input digit_t d);
    case (d)
      4'd0:        return 8'h3F;
      4'd1:        return 8'h06;
      4'd2:        return 8'h5B;
      4'd3:        return 8'h4F;
      4'd4:        return 8'h66;
      4'd5:        return 8'h6D;
      4'd6:        return 8'h7D;
      4'd7:        return 8'h07;
      4'd8:        return 8'h7F;
      4'd9:        return 8'h6F;
      c_dig_minus: return c_seg_minus;
      default:     return c_seg_blank;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_led_scan_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Iterative double-dabble converter, one shift-add-3 step per clock.
// Revision : 1.0
// ============================================================================
module bin2bcd_seq
  import seg_led_pkg::*;
#(
  parameter  int DATA_W = 20,
  localparam int c_nbcd = bcd_digits(DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     din,
  output logic                  busy,
  output logic                  done,
  output logic [4*c_nbcd-1:0]   bcd
);

  localparam int c_cnt_w = (clog2(DATA_W) > 0) ? clog2(DATA_W) : 1;
  localparam int c_bcd_w = 4 * c_nbcd;

  logic [DATA_W-1:0]  r_bin;
  logic [c_bcd_w-1:0] r_bcd;
  logic [c_bcd_w-1:0] w_adj;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < c_nbcd; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // bcd is the post-step value, so it is the final result during the done cycle.
  assign bcd  = {w_adj[c_bcd_w-2:0], r_bin[DATA_W-1]};
  assign done = r_busy && (r_cnt == c_cnt_w'(DATA_W - 1));
  assign busy = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_bin  <= '0;
      r_bcd  <= '0;
    end else if (r_busy) begin
      r_bcd <= bcd;
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt + c_cnt_w'(1);
      if (done) r_busy <= 1'b0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_bin  <= din;
      r_bcd  <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_led_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_led_scan
// Purpose  : Multiplexed N-digit seven-segment driver with sequential binary
//            to BCD conversion, sign, decimal points, blink and overflow.
// Revision : 1.0
// ============================================================================
module seg_led_scan
  import seg_led_pkg::*;
#(
  parameter int N_DIGITS       = 6,
  parameter int DATA_W         = 20,
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLINK_DIV      = 250,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data,
  input  logic                data_vld,
  input  logic                sign,
  input  logic [N_DIGITS-1:0] point,
  input  logic [N_DIGITS-1:0] blink,
  input  logic                en,
  output logic                busy,
  output logic [N_DIGITS-1:0] seg_sel,
  output logic [7:0]          seg_led
);

  localparam int c_div   = CLK_FREQ_HZ / SCAN_HZ;
  localparam int c_div_w = (clog2(c_div) > 0) ? clog2(c_div) : 1;
  localparam int c_idx_w = (clog2(N_DIGITS) > 0) ? clog2(N_DIGITS) : 1;
  localparam int c_blk_w = (clog2(BLINK_DIV) > 0) ? clog2(BLINK_DIV) : 1;
  localparam int c_nbcd  = bcd_digits(DATA_W);
  localparam int c_pad   = (c_nbcd > N_DIGITS) ? c_nbcd : N_DIGITS;

  localparam logic [N_DIGITS-1:0] c_sel_off = {N_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [7:0]          c_seg_off = {8{SEG_ACTIVE_LOW}};

  logic [c_div_w-1:0]          r_div;
  logic [c_idx_w-1:0]          r_idx;
  logic [c_blk_w-1:0]          r_bcnt;
  logic                        r_phase;
  logic                        w_tick;

  logic                        w_accept;
  logic                        w_busy;
  logic                        w_done;
  logic [4*c_nbcd-1:0]         w_bcd;
  logic [4*c_pad-1:0]          w_bcd_pad;

  logic                        r_sign_sh;
  logic [N_DIGITS-1:0]         r_point_sh;
  logic [N_DIGITS-1:0][3:0]    r_code;
  logic [N_DIGITS-1:0]         r_dp;

  int                          w_msd;
  int                          w_hp;
  int                          w_m;
  logic                        w_ovf;
  logic [N_DIGITS-1:0][3:0]    w_fmt_code;
  logic [N_DIGITS-1:0]         w_fmt_dp;

  digit_t                      w_cur;
  logic [7:0]                  w_led_ah;
  logic [N_DIGITS-1:0]         w_sel_ah;

  assign w_tick   = (r_div == c_div_w'(c_div - 1));
  assign w_accept = data_vld && !w_busy;
  assign busy     = w_busy;

  bin2bcd_seq #(
    .DATA_W (DATA_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_accept),
    .din   (data),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  assign w_bcd_pad = (4*c_pad)'(w_bcd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + c_div_w'(1);
      if (w_tick) begin
        r_idx <= (r_idx == c_idx_w'(N_DIGITS - 1)) ? '0 : r_idx + c_idx_w'(1);
        if (r_bcnt == c_blk_w'(BLINK_DIV - 1)) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + c_blk_w'(1);
        end
      end
    end
  end

  // A most-significant digit at index N_DIGITS or above means the value does not fit.
  always_comb begin
    w_msd      = 0;
    w_hp       = 0;
    w_ovf      = 1'b0;
    w_fmt_code = '0;
    w_fmt_dp   = '0;
    for (int i = 0; i < c_pad; i++) begin
      if (w_bcd_pad[4*i +: 4] != 4'd0) w_msd = i;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_point_sh[i]) w_hp = i;
    end
    w_m = (w_hp > w_msd) ? w_hp : w_msd;
    if (w_m >= N_DIGITS) w_ovf = 1'b1;
    if (r_sign_sh && (w_m == N_DIGITS - 1)) w_ovf = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_ovf)                           w_fmt_code[i] = c_dig_minus;
      else if (i <= w_m)                   w_fmt_code[i] = w_bcd_pad[4*i +: 4];
      else if (r_sign_sh && i == w_m + 1)  w_fmt_code[i] = c_dig_minus;
      else                                 w_fmt_code[i] = c_dig_blank;
      w_fmt_dp[i] = r_point_sh[i] && !w_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign_sh  <= 1'b0;
      r_point_sh <= '0;
      r_code     <= {N_DIGITS{c_dig_blank}};
      r_dp       <= '0;
    end else begin
      if (w_accept) begin
        r_sign_sh  <= sign;
        r_point_sh <= point;
      end
      if (w_done) begin
        r_code <= w_fmt_code;
        r_dp   <= w_fmt_dp;
      end
    end
  end

  always_comb begin
    w_cur    = r_code[r_idx];
    w_led_ah = seg_code(w_cur) | (r_dp[r_idx] ? c_seg_dp : 8'h00);
    if (blink[r_idx] && r_phase) w_led_ah = c_seg_blank;
    w_sel_ah        = '0;
    w_sel_ah[r_idx] = 1'b1;
  end

  // Select and segments share one register stage; the tick cycle is the blank slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_sel <= c_sel_off;
      seg_led <= c_seg_off;
    end else if (!en || w_tick) begin
      seg_sel <= c_sel_off;
      seg_led <= c_seg_off;
    end else begin
      seg_sel <= w_sel_ah ^ c_sel_off;
      seg_led <= w_led_ah ^ c_seg_off;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_led_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_led_scan
// Purpose  : Scoreboard bench for seg_led_scan with 8 clocks per digit.
// Revision : 1.0
// ============================================================================
module tb_seg_led_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] data = '0;
  logic        data_vld = 1'b0;
  logic        sign = 1'b0;
  logic [5:0]  point = '0;
  logic [5:0]  blink = '0;
  logic        en = 1'b1;
  logic        busy;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;

  seg_led_scan #(
    .N_DIGITS       (6),
    .DATA_W         (20),
    .CLK_FREQ_HZ    (8),
    .SCAN_HZ        (1),
    .BLINK_DIV      (2),
    .SEL_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .data_vld (data_vld),
    .sign     (sign),
    .point    (point),
    .blink    (blink),
    .en       (en),
    .busy     (busy),
    .seg_sel  (seg_sel),
    .seg_led  (seg_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] sel;
    logic [7:0] led;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         tb_cyc;
  logic       ghost_chk = 1'b0;
  logic [5:0] prev_sel = 6'h3F;
  logic [5:0] mon_oh;
  logic [5:0] mon_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  // Monitor: each new digit slot is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() != 0 && prev_sel == 6'h3F && seg_sel == sb[0].sel) begin
        n_tests++;
        if (seg_led !== sb[0].led) begin
          n_fail++;
          $display("FAIL scan sel=%b: seg_led=%h expected %h", seg_sel, seg_led, sb[0].led);
        end
        void'(sb.pop_front());
      end
      if (ghost_chk && tb_cyc != 0) begin
        mon_oh  = 6'b000001 << ((tb_cyc / 8) % 6);
        mon_exp = (tb_cyc % 8 == 0) ? 6'h3F : ~mon_oh;
        n_tests++;
        if (seg_sel !== mon_exp) begin
          n_fail++;
          $display("FAIL scan_timing cyc=%0d: seg_sel=%b expected %b", tb_cyc, seg_sel, mon_exp);
        end
      end
    end
    prev_sel = seg_sel;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // leds = {digit5, ..., digit0}
  task automatic expect_frame(input logic [47:0] leds);
    exp_t       e;
    logic [5:0] oh;
    #1;
    for (int i = 0; i < 6; i++) begin
      oh    = 6'b000001 << i;
      e.sel = ~oh;
      e.led = leds[8*i +: 8];
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: %0d expected digit slots never shown", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic load(input logic [19:0] d, input logic s, input logic [5:0] p, output int bc);
    @(negedge clk);
    data = d; sign = s; point = p; data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int bc;
    int k;
    int f;
    exp_t e;

    repeat (3) @(negedge clk);
    check("reset_sel", seg_sel, 6'h3F);
    check("reset_led", seg_led, 8'hFF);
    check("reset_busy", busy, 0);
    rst = 1'b0;

    // Load and scan with anti-ghost slot timing
    load(20'd123456, 1'b0, 6'b0, bc);
    check("busy_len_123456", bc, 20);
    expect_frame({8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});
    drain("frame_123456");
    ghost_chk = 1'b1;
    repeat (100) @(negedge clk);
    ghost_chk = 1'b0;

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    data = 20'd777; data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
    repeat (3) @(negedge clk);
    k = 0;
    while (seg_sel == 6'h3F && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("busy_before_reset", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_sel", seg_sel, 6'h3F);
    check("async_reset_led", seg_led, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    expect_frame({6{8'hFF}});
    drain("frame_after_reset");

    // Sign
    load(20'd42, 1'b1, 6'b0, bc);
    check("busy_len_42", bc, 20);
    expect_frame({8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h99, 8'hA4});
    drain("frame_neg42");

    // Decimal point extends the shown digits with leading zeros
    load(20'd5, 1'b0, 6'b000100, bc);
    check("busy_len_5", bc, 20);
    expect_frame({8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'h92});
    drain("frame_0.05");

    // Overflow and the full-width boundary
    load(20'd1000000, 1'b0, 6'b0, bc);
    expect_frame({6{8'hBF}});
    drain("frame_ovf_1000000");
    load(20'd999999, 1'b1, 6'b0, bc);
    expect_frame({6{8'hBF}});
    drain("frame_ovf_neg999999");
    load(20'd999999, 1'b0, 6'b0, bc);
    expect_frame({6{8'h90}});
    drain("frame_999999");

    // data_vld while busy, including on the final busy cycle, is ignored
    @(negedge clk);
    data = 20'd314; sign = 1'b0; point = 6'b0; data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      data     = 20'd999;
      sign     = 1'b1;
      data_vld = (bc == 5) || (bc == 20);
      @(negedge clk);
    end
    data_vld = 1'b0;
    sign     = 1'b0;
    check("busy_len_hs", bc, 20);
    @(negedge clk);
    check("no_restart_after_busy", busy, 0);
    expect_frame({8'hFF, 8'hFF, 8'hFF, 8'hB0, 8'hF9, 8'h99});
    drain("frame_314");

    // Blink on digit 0: blanked in odd frames (phase period 2 ticks, 6 ticks per frame)
    k = 0;
    while (seg_sel !== 6'b111110 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("digit0_reached", seg_sel, 6'b111110);
    f = tb_cyc / 48;
    blink = 6'b000001;
    #1;
    for (int j = 1; j <= 4; j++) begin
      e.sel = 6'b111110;
      e.led = (((f + j) % 2) == 1) ? 8'hFF : 8'h99;
      sb.push_back(e);
    end
    drain("blink_digit0");
    blink = 6'b0;

    // Display enable
    k = 0;
    while (!(seg_sel != 6'h3F && (tb_cyc % 8) < 6) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("active_before_en", (seg_sel != 6'h3F), 1);
    en = 1'b0;
    @(negedge clk);
    check("en0_sel", seg_sel, 6'h3F);
    check("en0_led", seg_led, 8'hFF);
    load(20'd86420, 1'b0, 6'b0, bc);
    check("busy_len_en0", bc, 20);
    check("en0_sel_later", seg_sel, 6'h3F);
    check("en0_led_later", seg_led, 8'hFF);
    en = 1'b1;
    expect_frame({8'hFF, 8'h80, 8'h82, 8'h99, 8'hA4, 8'hC0});
    drain("frame_86420");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
